uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//  Round-robin scheduler sharing one UART TX engine (sel/set/mode/din/baud -> tx_en) among NREQ requesters.
//  Arbitrates, latches the winner's frame, pulses the engine's load strobe, tracks the frame via tx_en,
//  then returns completion (or start-timeout error) to the winner. Sits between client logic and the TX engine.
// PARAMETERS
//  NREQ      4    number of requesters (2..8)
//  GAP_CYC   2    idle guard cycles between frames (0..15)
//  START_TMO 16   cycles allowed from load strobe to tx_en rising (>=2)
// PORTS
//  CLK       in   1        system clock, all logic rising-edge
//  RST       in   1        synchronous, active-high reset
//  req       in   NREQ     level request per client; held until gnt
//  req_data  in   10*NREQ  frame data, client i at [10*i+9:10*i]
//  req_mode  in   NREQ     per-client mode (0: 8-bit frame, 1: 10-bit frame)
//  baud_cfg  in   20       baud divisor, sampled at grant
//  gnt       out  NREQ     one-hot 1-cycle pulse: request accepted, data captured
//  done      out  NREQ     one-hot 1-cycle pulse: frame fully transmitted
//  err       out  NREQ     one-hot 1-cycle pulse: engine never started (timeout)
//  busy      out  1        high whenever state != IDLE
//  tx_sel    out  1        engine select
//  tx_set    out  1        engine load strobe (1-cycle)
//  tx_mode   out  1        latched mode
//  tx_din    out  10       latched data
//  tx_baud   out  20       latched baud divisor
//  tx_en     in   1        engine transmitting (high for whole frame)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer 0; counters 0. RST mid-frame aborts at once, no done/err.
//  FSM (all outputs registered):
//   IDLE  : any req -> LOAD. Winner = first set bit scanning ptr, ptr+1, ... mod NREQ.
//           On transition: tx_din/tx_mode/tx_baud <= winner's data/mode/baud_cfg; owner <= winner;
//           ptr <= (winner+1) mod NREQ.
//   LOAD  : 1 cycle. gnt[owner]=1, tx_set=1, tx_sel=1. -> WAITS; tmo counter cleared.
//   WAITS : tx_sel=1. tx_en=1 -> BUSY. Else tmo++; tmo reaches START_TMO-1 -> err[owner] pulse, -> GAP.
//   BUSY  : tx_sel=1. tx_en=0 -> done[owner] pulse on exit cycle, -> GAP.
//   GAP   : tx_sel=0; count GAP_CYC cycles then -> IDLE (GAP_CYC=0: straight to IDLE, 1 cycle in GAP).
//  Latency: req high in IDLE at cycle N -> gnt/tx_set at N+1. tx_en falls at M -> done at M+1.
//  tx_din/tx_mode/tx_baud stay stable LOAD..GAP; changes on req_data/baud_cfg after grant are ignored.
//  Requests arriving while busy wait; a req dropped before grant is never served (no memory).
//  Same-cycle requests: scan order from ptr decides; ptr advance guarantees each waiting client
//   is served within NREQ frames (fairness).
//  ptr wraps NREQ-1 -> 0. gnt, done, err are mutually exclusive and at most one bit each.
//  tx_en high in IDLE/GAP (spurious) is ignored; tx_en low at LOAD-exit is normal.
// TESTING
//  1) Single req[1], data 10'h0A5, mode 0, baud 20'd868; tx_en high 3..40 after set
//     -> gnt=4'b0010 at N+1, tx_din=0A5, tx_baud=868, done[1] 1 cycle after tx_en falls.
//  2) req=4'b1111 held, ptr=0 -> grants in order 0,1,2,3,0; each gnt pulse exactly 1 cycle.
//  3) tx_en never rises -> err[owner] after START_TMO=16 cycles in WAITS, no done, busy drops after GAP.
//  4) req_data changed mid-frame -> tx_din unchanged until next LOAD.
//  5) RST asserted during BUSY -> next cycle all outputs 0, state IDLE, ptr 0, no done pulse.
//  6) GAP_CYC=2: tx_sel low for exactly 2 cycles between done and next tx_set with req pending.

Source files
------------

// File: rtl/uart_tx_sched.sv
// ============================================================================
// Module   : uart_tx_sched
// Purpose  : Round-robin scheduler sharing one UART TX engine among NREQ
//            requesters; latches the winning frame, strobes the engine and
//            returns a done/err pulse to the owner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_sched #(
    parameter int NREQ      = 4,
    parameter int GAP_CYC   = 2,
    parameter int START_TMO = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req,
    input  logic [10*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]      req_mode,
    input  logic [19:0]          baud_cfg,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic                 busy,
    output logic                 tx_sel,
    output logic                 tx_set,
    output logic                 tx_mode,
    output logic [9:0]           tx_din,
    output logic [19:0]          tx_baud,
    input  logic                 tx_en
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(START_TMO);
    localparam logic [PW:0]   NREQ_W   = (PW+1)'(NREQ);
    localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(START_TMO - 1);
    localparam logic [3:0]    GAP_LAST = (GAP_CYC == 0) ? 4'd0 : 4'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAITS = 3'd2,
        S_BUSY  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [3:0]        gap_q, gap_d;
    logic [9:0]        tx_din_q, tx_din_d;
    logic              tx_mode_q, tx_mode_d;
    logic [19:0]       tx_baud_q, tx_baud_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic              busy_q, busy_d;
    logic              tx_sel_q, tx_sel_d;
    logic              tx_set_q, tx_set_d;

    logic [9:0]        data_arr [NREQ];
    logic [PW:0]       sum;
    logic [PW-1:0]     cand;
    logic              win_found;
    logic [PW-1:0]     win_idx;

    // Scan starts at ptr and wraps, so the client after the last winner has top priority
    always_comb begin
        sum       = '0;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int j = 0; j < NREQ; j++) begin
            data_arr[j] = req_data[10*j +: 10];
        end
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            cand = sum[PW-1:0];
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        tmo_d     = tmo_q;
        gap_d     = gap_q;
        tx_din_d  = tx_din_q;
        tx_mode_d = tx_mode_q;
        tx_baud_d = tx_baud_q;
        gnt_d     = '0;
        done_d    = '0;
        err_d     = '0;
        tx_set_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d        = S_LOAD;
                    owner_d        = win_idx;
                    ptr_d          = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
                    tx_din_d       = data_arr[win_idx];
                    tx_mode_d      = req_mode[win_idx];
                    tx_baud_d      = baud_cfg;
                    gnt_d[win_idx] = 1'b1;
                    tx_set_d       = 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_WAITS;
                tmo_d   = '0;
            end
            S_WAITS: begin
                if (tx_en) begin
                    state_d = S_BUSY;
                end else if (tmo_q == TMO_LAST) begin
                    err_d[owner_q] = 1'b1;
                    state_d        = S_GAP;
                    gap_d          = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_BUSY: begin
                if (!tx_en) begin
                    done_d[owner_q] = 1'b1;
                    state_d         = S_GAP;
                    gap_d           = '0;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they align with it
        tx_sel_d = (state_d == S_LOAD) || (state_d == S_WAITS) || (state_d == S_BUSY);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            tmo_q     <= '0;
            gap_q     <= '0;
            tx_din_q  <= '0;
            tx_mode_q <= 1'b0;
            tx_baud_q <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
            tx_sel_q  <= 1'b0;
            tx_set_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
            tx_din_q  <= tx_din_d;
            tx_mode_q <= tx_mode_d;
            tx_baud_q <= tx_baud_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            tx_sel_q  <= tx_sel_d;
            tx_set_q  <= tx_set_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign tx_sel  = tx_sel_q;
    assign tx_set  = tx_set_q;
    assign tx_mode = tx_mode_q;
    assign tx_din  = tx_din_q;
    assign tx_baud = tx_baud_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
// ============================================================================
// Module   : tb_uart_tx_sched
// Purpose  : Self-checking bench for uart_tx_sched with a timestamp-based
//            frame model and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_sched;

    localparam int NREQ      = 4;
    localparam int GAP_CYC   = 2;
    localparam int START_TMO = 16;
    localparam int GAP_LEN   = (GAP_CYC == 0) ? 1 : GAP_CYC;

    logic                CLK = 1'b0;
    logic                RST;
    logic [NREQ-1:0]     req;
    logic [10*NREQ-1:0]  req_data;
    logic [NREQ-1:0]     req_mode;
    logic [19:0]         baud_cfg;
    logic [NREQ-1:0]     gnt, done, err;
    logic                busy, tx_sel, tx_set, tx_mode, tx_en;
    logic [9:0]          tx_din;
    logic [19:0]         tx_baud;

    always #5 CLK = ~CLK;

    uart_tx_sched #(.NREQ(NREQ), .GAP_CYC(GAP_CYC), .START_TMO(START_TMO)) dut (
        .CLK(CLK), .RST(RST), .req(req), .req_data(req_data), .req_mode(req_mode),
        .baud_cfg(baud_cfg), .gnt(gnt), .done(done), .err(err), .busy(busy),
        .tx_sel(tx_sel), .tx_set(tx_set), .tx_mode(tx_mode), .tx_din(tx_din),
        .tx_baud(tx_baud), .tx_en(tx_en)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame model: one active frame described by its load cycle, end cycle and free cycle
    int          c       = 0;
    bit          m_act   = 1'b0;
    int          m_own   = 0;
    int          m_load  = 0;
    int          m_end   = -1;
    int          m_free  = 0;
    bit          m_start = 1'b0;
    bit          m_iserr = 1'b0;
    int          m_ptr   = 0;
    int          m_win;
    logic [9:0]  m_din   = '0;
    logic        m_mode  = 1'b0;
    logic [19:0] m_baud  = '0;
    logic [NREQ-1:0] e_gnt, e_done, e_err;
    logic        e_sel, e_busy;

    // Event log consumed by the directed scenarios
    int set_cyc = 0, done_cyc = 0, err_cyc = 0, n_done = 0, n_err = 0;
    logic [NREQ-1:0] done_val = '0, err_val = '0;
    int gnt_log[$];

    always @(negedge CLK) begin
        e_gnt  = '0;
        e_done = '0;
        e_err  = '0;
        if (m_act && c == m_load) e_gnt[m_own] = 1'b1;
        if (m_act && m_end >= 0 && c == m_end) begin
            if (m_iserr) e_err[m_own] = 1'b1;
            else         e_done[m_own] = 1'b1;
        end
        e_sel  = m_act && c >= m_load && (m_end < 0 || c < m_end);
        e_busy = m_act && c >= m_load && (m_end < 0 || c < m_free);

        check("gnt", 32'(gnt), 32'(e_gnt));
        check("tx_set", 32'(tx_set), 32'(e_gnt != 0));
        check("done", 32'(done), 32'(e_done));
        check("err", 32'(err), 32'(e_err));
        check("tx_sel", 32'(tx_sel), 32'(e_sel));
        check("busy", 32'(busy), 32'(e_busy));
        check("tx_frame", 32'({tx_mode, tx_baud, tx_din}), 32'({m_mode, m_baud, m_din}));

        if (gnt != 0) begin
            set_cyc = c;
            for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_log.push_back(i);
        end
        if (done != 0) begin done_cyc = c; done_val = done; n_done++; end
        if (err != 0)  begin err_cyc = c;  err_val = err;   n_err++;  end

        if (RST) begin
            m_act  = 1'b0;
            m_ptr  = 0;
            m_din  = '0;
            m_mode = 1'b0;
            m_baud = '0;
        end else if (!m_act || (m_end >= 0 && c >= m_free)) begin
            m_act = 1'b0;
            m_win = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (m_win < 0 && req[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
            end
            if (m_win >= 0) begin
                m_act   = 1'b1;
                m_own   = m_win;
                m_load  = c + 1;
                m_end   = -1;
                m_start = 1'b0;
                m_din   = req_data[10*m_win +: 10];
                m_mode  = req_mode[m_win];
                m_baud  = baud_cfg;
                m_ptr   = (m_win + 1) % NREQ;
            end
        end else if (m_end < 0 && c > m_load) begin
            if (!m_start) begin
                if (tx_en) begin
                    m_start = 1'b1;
                end else if (c - m_load == START_TMO) begin
                    m_end   = c + 1;
                    m_iserr = 1'b1;
                    m_free  = m_end + GAP_LEN;
                end
            end else if (!tx_en) begin
                m_end   = c + 1;
                m_iserr = 1'b0;
                m_free  = m_end + GAP_LEN;
            end
        end
        c++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Returns at the start of the cycle after the load strobe
    task automatic wait_set();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge CLK);
            if (tx_set) found = 1'b1;
        end
        check("wait_set_timeout", 32'(found), 32'd1);
        tick();
    endtask

    task automatic wait_evt();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge CLK);
            if (done != 0 || err != 0) found = 1'b1;
        end
        check("wait_evt_timeout", 32'(found), 32'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, nd, prev_done;
        RST = 1'b1; req = '0; req_data = '0; req_mode = '0; baud_cfg = '0; tx_en = 1'b0;
        repeat (3) tick();
        RST = 1'b0;
        @(negedge CLK);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        tick();

        // Single request on client 1, data changed mid-frame
        req_data[19:10] = 10'h0A5;
        req_mode[1]     = 1'b0;
        baud_cfg        = 20'd868;
        req             = 4'b0010;
        tick();
        @(negedge CLK);
        check("t1_gnt", 32'(gnt), 32'h2);
        check("t1_din", 32'(tx_din), 32'h0A5);
        check("t1_baud", 32'(tx_baud), 32'd868);
        tick();
        req = '0;
        repeat (2) tick();
        tx_en = 1'b1;
        repeat (7) tick();
        req_data[19:10] = 10'h3FF;
        baud_cfg        = 20'd12345;
        tick();
        @(negedge CLK);
        check("t4_din_hold", 32'(tx_din), 32'h0A5);
        check("t4_baud_hold", 32'(tx_baud), 32'd868);
        repeat (30) tick();
        tx_en = 1'b0;
        wait_evt();
        check("t1_done_lat", 32'(done_cyc - set_cyc), 32'd42);
        check("t1_done_val", 32'(done_val), 32'h2);

        // Engine never starts on client 2
        req_data[29:20] = 10'h155;
        req_mode[2]     = 1'b1;
        req             = 4'b0100;
        wait_set();
        req = '0;
        nd  = n_done;
        wait_evt();
        check("t3_err_lat", 32'(err_cyc - set_cyc), 32'(START_TMO + 1));
        check("t3_err_val", 32'(err_val), 32'h4);
        check("t3_no_done", 32'(n_done), 32'(nd));
        tick();
        @(negedge CLK);
        check("t3_busy_drop", 32'(busy), 32'd0);
        tick();
        tx_en = 1'b1;
        repeat (4) tick();
        tx_en = 1'b0;

        // Reset during BUSY aborts the frame and clears the pointer
        req = 4'b0010;
        wait_set();
        req = '0;
        tick();
        tx_en = 1'b1;
        repeat (5) tick();
        nd  = n_done;
        RST = 1'b1;
        tick();
        RST   = 1'b0;
        tx_en = 1'b0;
        @(negedge CLK);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_sel", 32'(tx_sel), 32'd0);
        check("t5_din", 32'(tx_din), 32'd0);
        repeat (4) tick();
        check("t5_no_done", 32'(n_done), 32'(nd));

        // All clients requesting: round-robin order and guard gap
        req_data  = {10'h344, 10'h233, 10'h122, 10'h011};
        req_mode  = 4'b1010;
        baud_cfg  = 20'd434;
        base      = gnt_log.size();
        prev_done = 0;
        req       = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            wait_set();
            if (f > 0) check("t6_gap", 32'(set_cyc - prev_done - 1), 32'd2);
            if (f == 4) req = '0;
            tick();
            tx_en = 1'b1;
            repeat (4) tick();
            tx_en = 1'b0;
            wait_evt();
            prev_done = done_cyc;
        end
        check("t2_cnt", 32'(gnt_log.size() - base), 32'd5);
        if (gnt_log.size() - base == 5) begin
            check("t2_g0", 32'(gnt_log[base]),     32'd0);
            check("t2_g1", 32'(gnt_log[base + 1]), 32'd1);
            check("t2_g2", 32'(gnt_log[base + 2]), 32'd2);
            check("t2_g3", 32'(gnt_log[base + 3]), 32'd3);
            check("t2_g4", 32'(gnt_log[base + 4]), 32'd0);
        end

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
